// File: rtl/packet_framer_pkg.sv
// Shared constants, state encoding and byte-enable helpers for the packet framer.
// Byte 0 of every beat sits in the MSBs; byte-enable bit 7 qualifies byte 0.
package packet_framer_pkg;

   localparam int DATA_BYTES  = 8;
   localparam int HDR_A_BYTES = 4;
   localparam int HDR_B_BYTES = 4;
   localparam int HDR_C_BYTES = 4;
   localparam int HDR_OFFSET  = (HDR_A_BYTES + HDR_B_BYTES + HDR_C_BYTES) % DATA_BYTES;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR0 = 3'd1,
      HDR1 = 3'd2,
      BODY = 3'd3,
      TAIL = 3'd4
   } framer_state_t;

   // Byte enable with the top n bytes set; n above DATA_BYTES saturates to all ones.
   function automatic logic [7:0] be_from_count(input logic [3:0] n);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(n)) r[7-i] = 1'b1;
      end
      return r;
   endfunction

   // Count of consecutive ones starting at byte 0 (bit 7).
   function automatic logic [3:0] lead_ones(input logic [7:0] be);
      logic [3:0] c;
      logic       run;
      c   = 4'd0;
      run = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         if (run && be[i]) c = c + 4'd1;
         else              run = 1'b0;
      end
      return c;
   endfunction

   function automatic logic [63:0] be_to_mask(input logic [7:0] be);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
      return m;
   endfunction

endpackage

// File: rtl/packet_framer_if.sv
// Header, payload and framed-output signals of the packet framer.
// master = upstream/downstream environment, slave = the framer itself.
interface packet_framer_if;

   logic [31:0] iHeader_A;
   logic [31:0] iHeader_B;
   logic [31:0] iHeader_C;
   logic        iHeader_valid;
   logic        oHeader_ready;

   logic [63:0] iPayload;
   logic        iPayload_valid;
   logic        oPayload_ready;
   logic        iSop;
   logic        iEop;
   logic [7:0]  iByte_enable;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // a producer holds its beat unchanged while valid is high and ready is low.
   logic [63:0] oPacket;
   logic        oValid;
   logic        iReady;
   logic        oSop;
   logic        oEop;
   logic [7:0]  oByte_enable;
   logic        oProtocol_error;

   modport master (
      output iHeader_A, iHeader_B, iHeader_C, iHeader_valid,
      output iPayload, iPayload_valid, iSop, iEop, iByte_enable,
      output iReady,
      input  oHeader_ready, oPayload_ready,
      input  oPacket, oValid, oSop, oEop, oByte_enable, oProtocol_error
   );

   modport slave (
      input  iHeader_A, iHeader_B, iHeader_C, iHeader_valid,
      input  iPayload, iPayload_valid, iSop, iEop, iByte_enable,
      input  iReady,
      output oHeader_ready, oPayload_ready,
      output oPacket, oValid, oSop, oEop, oByte_enable, oProtocol_error
   );

endinterface

// File: rtl/packet_framer_realign_buf.sv
// 4-byte carry register and merge mux that re-aligns payload behind the 12-byte header,
// plus the eop byte-count split between the merged beat and the trailing beat.
module framer_realign_buf
   import packet_framer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        carry_load,
   input  logic        use_hdr_c,
   input  logic [31:0] hdr_c,
   input  logic [63:0] payload,
   input  logic        eop,
   input  logic [7:0]  byte_enable,
   output logic [63:0] merged,
   output logic [63:0] tail,
   output logic        short_eop,
   output logic        long_eop,
   output logic [7:0]  be_merged,
   output logic [7:0]  be_tail,
   output logic        be_error
);

   logic [31:0] carry;
   logic [3:0]  carry_cnt;
   logic [3:0]  n;
   logic [31:0] head;

   always_comb begin
      n         = eop ? lead_ones(byte_enable) : 4'd8;
      short_eop = eop && (n <= 4'd4);
      long_eop  = eop && (n > 4'd4);
      be_error  = eop && (byte_enable != be_from_count(lead_ones(byte_enable)));
      be_merged = short_eop ? be_from_count(n + 4'd4) : 8'hFF;
      head      = use_hdr_c ? hdr_c : carry;
      merged    = {head, payload[63:32]} & be_to_mask(be_merged);
      // carry_cnt holds the full byte count of the eop beat that spilled into TAIL
      be_tail   = be_from_count(carry_cnt - 4'd4);
      tail      = {carry, 32'h0} & be_to_mask(be_tail);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry     <= 32'h0;
         carry_cnt <= 4'd0;
      end else if (carry_load) begin
         carry     <= payload[31:0];
         carry_cnt <= n;
      end
   end

endmodule

// File: rtl/packet_framer.sv
// Transmit framer: emits header A|B, then C followed by the payload shifted by 4 bytes,
// with registered sop/eop/byte-enable and a one-cycle pulse on input framing violations.
module packet_framer
   import packet_framer_pkg::*;
(
   input  logic          iClk,
   input  logic          iReset,
   packet_framer_if.slave bus,
   output framer_state_t state_dbg
);

   framer_state_t state, state_d;

   logic [31:0] hdr_a, hdr_b, hdr_c;
   logic [63:0] pkt_q, pkt_d;
   logic        valid_q, valid_d;
   logic        sop_q, sop_d;
   logic        eop_q, eop_d;
   logic [7:0]  be_q, be_d;
   logic        err_q, err_d;

   logic        load_en;
   logic        payload_ready;
   logic        payload_fire;
   logic        header_fire;
   logic        carry_load;
   logic        use_hdr_c;

   logic [63:0] merged, tail;
   logic        short_eop, long_eop, be_error;
   logic [7:0]  be_merged, be_tail;

   // The output register may take a new beat whenever it is empty or being drained.
   assign load_en       = !valid_q || bus.iReady;
   assign payload_ready = ((state == HDR1) || (state == BODY)) && load_en;
   assign payload_fire  = payload_ready && bus.iPayload_valid;
   assign header_fire   = (state == IDLE) && bus.iHeader_valid;

   assign bus.oHeader_ready   = (state == IDLE);
   assign bus.oPayload_ready  = payload_ready;
   assign bus.oPacket         = pkt_q;
   assign bus.oValid          = valid_q;
   assign bus.oSop            = sop_q;
   assign bus.oEop            = eop_q;
   assign bus.oByte_enable    = be_q;
   assign bus.oProtocol_error = err_q;
   assign state_dbg           = state;

   framer_realign_buf u_realign (
      .clk         (iClk),
      .rst_n       (iReset),
      .carry_load  (carry_load),
      .use_hdr_c   (use_hdr_c),
      .hdr_c       (hdr_c),
      .payload     (bus.iPayload),
      .eop         (bus.iEop),
      .byte_enable (bus.iByte_enable),
      .merged      (merged),
      .tail        (tail),
      .short_eop   (short_eop),
      .long_eop    (long_eop),
      .be_merged   (be_merged),
      .be_tail     (be_tail),
      .be_error    (be_error)
   );

   always_comb begin
      state_d    = state;
      pkt_d      = pkt_q;
      valid_d    = valid_q;
      sop_d      = sop_q;
      eop_d      = eop_q;
      be_d       = be_q;
      err_d      = 1'b0;
      carry_load = 1'b0;
      use_hdr_c  = 1'b0;
      if (load_en) valid_d = 1'b0;
      case (state)
         IDLE: begin
            if (header_fire) state_d = HDR0;
         end
         HDR0: begin
            if (load_en) begin
               pkt_d   = {hdr_a, hdr_b};
               valid_d = 1'b1;
               sop_d   = 1'b1;
               eop_d   = 1'b0;
               be_d    = 8'hFF;
               state_d = HDR1;
            end
         end
         HDR1, BODY: begin
            use_hdr_c = (state == HDR1);
            if (payload_fire) begin
               pkt_d   = merged;
               valid_d = 1'b1;
               sop_d   = 1'b0;
               eop_d   = short_eop;
               be_d    = be_merged;
               // A missing sop on the first beat or a stray sop mid-packet is flagged but not acted on.
               err_d   = ((state == HDR1) ? !bus.iSop : bus.iSop) || be_error;
               if (short_eop) begin
                  state_d = IDLE;
               end else begin
                  carry_load = 1'b1;
                  state_d    = long_eop ? TAIL : BODY;
               end
            end
         end
         TAIL: begin
            if (load_en) begin
               pkt_d   = tail;
               valid_d = 1'b1;
               sop_d   = 1'b0;
               eop_d   = 1'b1;
               be_d    = be_tail;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         state   <= IDLE;
         hdr_a   <= 32'h0;
         hdr_b   <= 32'h0;
         hdr_c   <= 32'h0;
         pkt_q   <= 64'h0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         be_q    <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state   <= state_d;
         pkt_q   <= pkt_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         be_q    <= be_d;
         err_q   <= err_d;
         if (header_fire) begin
            hdr_a <= bus.iHeader_A;
            hdr_b <= bus.iHeader_B;
            hdr_c <= bus.iHeader_C;
         end
      end
   end

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer: drivers push expected framed beats into a queue,
// an independent monitor pops and compares every accepted output beat.
module tb_packet_framer;
   import packet_framer_pkg::*;

   typedef logic [73:0] beat_t;

   logic          iClk;
   logic          iReset;
   framer_state_t state_dbg;
   packet_framer_if bus ();

   packet_framer dut (
      .iClk      (iClk),
      .iReset    (iReset),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   int    n_cmp = 0;
   int    n_bad = 0;
   int    err_cycles = 0;
   logic  rdy_rand = 1'b0;
   logic  hold_pend = 1'b0;
   beat_t snap;
   beat_t exp_q[$];

   localparam logic [31:0] HA = 32'hA0A1A2A3;
   localparam logic [31:0] HB = 32'hB0B1B2B3;
   localparam logic [31:0] HC = 32'hC0C1C2C3;

   // ---------------- clock / reset ----------------
   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic beat_t mk(input logic [63:0] d, input logic s, input logic e, input logic [7:0] be);
      return {d, s, e, be};
   endfunction

   // ---------------- ready driver ----------------
   initial begin
      bus.iReady = 1'b1;
      forever begin
         @(posedge iClk);
         #1;
         bus.iReady = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge iClk) begin
      beat_t cur;
      beat_t e;
      cur = {bus.oPacket, bus.oSop, bus.oEop, bus.oByte_enable};
      if (!iReset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) check("hold_stable", 80'({bus.oValid, cur}), 80'({1'b1, snap}));
         if (bus.oValid && bus.iReady) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: got %h, expected no beat", cur);
            end else begin
               e = exp_q.pop_front();
               check("beat", 80'(cur), 80'(e));
            end
         end
         if (bus.oProtocol_error) err_cycles++;
         hold_pend = bus.oValid && !bus.iReady;
         snap      = cur;
      end
   end

   // ---------------- driver tasks (enter and leave just after a rising edge) ----------------
   task automatic send_header(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      int   t;
      logic acc;
      bus.iHeader_A     = a;
      bus.iHeader_B     = b;
      bus.iHeader_C     = c;
      bus.iHeader_valid = 1'b1;
      t = 0;
      do begin
         @(negedge iClk);
         acc = bus.oHeader_ready;
         @(posedge iClk);
         #1;
         t++;
      end while (!acc && t < 200);
      if (!acc) check("header_timeout", 80'(0), 80'(1));
      bus.iHeader_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic s, input logic e, input logic [7:0] be);
      int   t;
      logic acc;
      bus.iPayload       = d;
      bus.iSop           = s;
      bus.iEop           = e;
      bus.iByte_enable   = be;
      bus.iPayload_valid = 1'b1;
      t = 0;
      do begin
         @(negedge iClk);
         acc = bus.oPayload_ready;
         @(posedge iClk);
         #1;
         t++;
      end while (!acc && t < 200);
      if (!acc) check("payload_timeout", 80'(0), 80'(1));
      bus.iPayload_valid = 1'b0;
      bus.iSop           = 1'b0;
      bus.iEop           = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(posedge iClk);
         #1;
         t++;
      end
      check(name, 80'(exp_q.size()), 80'(0));
      repeat (4) begin
         @(posedge iClk);
         #1;
      end
   endtask

   // 14-byte payload: two input beats, four framed beats including a TAIL beat.
   task automatic run_case1(input string name);
      exp_q.push_back(mk({HA, HB}, 1'b1, 1'b0, 8'hFF));
      exp_q.push_back(mk({HC, 32'h00010203}, 1'b0, 1'b0, 8'hFF));
      exp_q.push_back(mk(64'h04050607_08090A0B, 1'b0, 1'b0, 8'hFF));
      exp_q.push_back(mk(64'h0C0D0000_00000000, 1'b0, 1'b1, 8'hC0));
      send_header(HA, HB, HC);
      send_beat(64'h00010203_04050607, 1'b1, 1'b0, 8'hFF);
      send_beat(64'h08090A0B_0C0DEEEE, 1'b0, 1'b1, 8'hFC);
      wait_drain(name);
   endtask

   // 3-byte single-beat payload.
   task automatic run_case2(input string name);
      exp_q.push_back(mk({HA, HB}, 1'b1, 1'b0, 8'hFF));
      exp_q.push_back(mk({HC, 32'h00010200}, 1'b0, 1'b1, 8'hFE));
      send_header(HA, HB, HC);
      send_beat(64'h00010200_00000000, 1'b1, 1'b1, 8'hE0);
      wait_drain(name);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      iReset             = 1'b0;
      bus.iHeader_A      = '0;
      bus.iHeader_B      = '0;
      bus.iHeader_C      = '0;
      bus.iHeader_valid  = 1'b0;
      bus.iPayload       = '0;
      bus.iPayload_valid = 1'b0;
      bus.iSop           = 1'b0;
      bus.iEop           = 1'b0;
      bus.iByte_enable   = 8'hFF;

      repeat (3) @(posedge iClk);
      @(negedge iClk);
      check("rst_valid",    80'(bus.oValid),          80'(0));
      check("rst_hdr_rdy",  80'(bus.oHeader_ready),   80'(1));
      check("rst_pay_rdy",  80'(bus.oPayload_ready),  80'(0));
      check("rst_packet",   80'(bus.oPacket),         80'(0));
      check("rst_be",       80'(bus.oByte_enable),    80'(0));
      check("rst_sop_eop",  80'({bus.oSop, bus.oEop}), 80'(0));
      check("rst_err",      80'(bus.oProtocol_error), 80'(0));
      check("rst_state",    80'(state_dbg),           80'(IDLE));
      @(posedge iClk);
      #1;
      iReset = 1'b1;
      @(posedge iClk);
      #1;

      run_case1("drain_case1");
      run_case2("drain_case2");

      // 8-byte payload in one beat: spills 4 bytes into a TAIL beat.
      exp_q.push_back(mk({HA, HB}, 1'b1, 1'b0, 8'hFF));
      exp_q.push_back(mk({HC, 32'h00010203}, 1'b0, 1'b0, 8'hFF));
      exp_q.push_back(mk(64'h04050607_00000000, 1'b0, 1'b1, 8'hF0));
      send_header(HA, HB, HC);
      send_beat(64'h00010203_04050607, 1'b1, 1'b1, 8'hFF);
      wait_drain("drain_case3");

      rdy_rand = 1'b1;
      run_case1("drain_case4");
      rdy_rand = 1'b0;
      repeat (2) begin
         @(posedge iClk);
         #1;
      end

      // Reset while a packet sits in BODY.
      exp_q.push_back(mk({HA, HB}, 1'b1, 1'b0, 8'hFF));
      exp_q.push_back(mk({HC, 32'h00010203}, 1'b0, 1'b0, 8'hFF));
      send_header(HA, HB, HC);
      send_beat(64'h00010203_04050607, 1'b1, 1'b0, 8'hFF);
      check("state_body", 80'(state_dbg), 80'(BODY));
      @(negedge iClk);
      #1;
      iReset = 1'b0;
      @(negedge iClk);
      check("rst5_valid",   80'(bus.oValid),        80'(0));
      check("rst5_hdr_rdy", 80'(bus.oHeader_ready), 80'(1));
      check("rst5_eop",     80'(bus.oEop),          80'(0));
      check("rst5_queue",   80'(exp_q.size()),      80'(0));
      @(posedge iClk);
      #1;
      iReset = 1'b1;
      @(posedge iClk);
      #1;
      run_case2("drain_case5");
      check("no_err_so_far", 80'(err_cycles), 80'(0));

      // Stray sop in BODY: flagged for one cycle, data framed as a continuation.
      exp_q.push_back(mk({HA, HB}, 1'b1, 1'b0, 8'hFF));
      exp_q.push_back(mk({HC, 32'h00010203}, 1'b0, 1'b0, 8'hFF));
      exp_q.push_back(mk(64'h04050607_08090A0B, 1'b0, 1'b0, 8'hFF));
      exp_q.push_back(mk(64'h0C0D0E0F_10111213, 1'b0, 1'b1, 8'hFF));
      send_header(HA, HB, HC);
      send_beat(64'h00010203_04050607, 1'b1, 1'b0, 8'hFF);
      send_beat(64'h08090A0B_0C0D0E0F, 1'b1, 1'b0, 8'hFF);
      send_beat(64'h10111213_00000000, 1'b0, 1'b1, 8'hF0);
      wait_drain("drain_case6");
      check("err_pulse_cycles", 80'(err_cycles), 80'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
